// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state/kind types and constants for MIPS control-transfer sequencing
package mips_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, SLOT, REDIRECT, NULLIFY} state_t;
  typedef enum logic [1:0] {KIND_BRANCH, KIND_JUMP, KIND_JR} kind_t;
  localparam logic [31:0] PC_INC = 32'd4;
  localparam logic [31:0] LINK_OFFSET = 32'd8;
  localparam logic [4:0] LINK_REG_DEFAULT = 5'd31;
endpackage

// File: rtl/branch_delay_ctrl_if.sv
// branch_delay_ctrl_if: decode/comparator inputs and fetch/regfile outputs of branch_delay_ctrl
interface branch_delay_ctrl_if;
  logic stall, dec_valid, dec_is_branch, dec_is_jump, dec_is_jr, dec_link, dec_likely, cmp_taken;
  logic [4:0] dec_link_rd;
  logic [31:0] dec_pc, dec_rs_val;
  logic [15:0] dec_imm;
  logic [25:0] dec_target26;
  logic redirect_valid, link_we, nullify, busy;
  logic [31:0] redirect_pc, link_value;
  logic [4:0] link_reg;
  modport master(
    output stall, dec_valid, dec_is_branch, dec_is_jump, dec_is_jr, dec_link, dec_likely, cmp_taken,
           dec_link_rd, dec_pc, dec_rs_val, dec_imm, dec_target26,
    input redirect_valid, redirect_pc, link_we, link_reg, link_value, nullify, busy
  );
  modport slave(
    input stall, dec_valid, dec_is_branch, dec_is_jump, dec_is_jr, dec_link, dec_likely, cmp_taken,
          dec_link_rd, dec_pc, dec_rs_val, dec_imm, dec_target26,
    output redirect_valid, redirect_pc, link_we, link_reg, link_value, nullify, busy
  );
endinterface

// File: rtl/branch_target_calc.sv
// branch_target_calc: combinational target address for branch, J-type and register jumps
module branch_target_calc import mips_ctrl_pkg::*; (
  input  logic [31:0] pc,
  input  logic [15:0] imm,
  input  logic [25:0] target26,
  input  logic [31:0] rs_val,
  input  kind_t       kind,
  output logic [31:0] target
);
  logic [31:0] pc4;
  assign pc4 = pc + PC_INC;
  always_comb target = kind == KIND_JR ? rs_val :
                       kind == KIND_JUMP ? {pc4[31:28], target26, 2'b00} :
                       pc4 + {{14{imm[15]}}, imm, 2'b00};
endmodule

// File: rtl/branch_delay_ctrl.sv
// branch_delay_ctrl: delay-slot sequencing, registered PC redirect and link writeback.
// Define BRANCH_LIKELY_EN to squash the delay slot of untaken branch-likely instructions.
module branch_delay_ctrl import mips_ctrl_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  parameter logic [4:0]  LINK_REG = LINK_REG_DEFAULT
) (
  input logic clk,
  input logic reset,
  branch_delay_ctrl_if.slave bus
);
  state_t state, state_n;
  kind_t kind;
  logic [31:0] target, target_q;
  logic issue, accept, taken, likely_miss;
  assign issue = bus.dec_valid & ~bus.stall;
  assign accept = (state == IDLE) & issue;
  assign taken = bus.dec_is_jump | bus.dec_is_jr | (bus.dec_is_branch & bus.cmp_taken);
  assign kind = bus.dec_is_jr ? KIND_JR : bus.dec_is_jump ? KIND_JUMP : KIND_BRANCH;
`ifdef BRANCH_LIKELY_EN
  assign likely_miss = bus.dec_is_branch & bus.dec_likely & ~bus.cmp_taken;
`else
  logic unused;
  assign unused = bus.dec_likely;
  assign likely_miss = 1'b0;
`endif
  branch_target_calc u_calc (
    .pc(bus.dec_pc),
    .imm(bus.dec_imm),
    .target26(bus.dec_target26),
    .rs_val(bus.dec_rs_val),
    .kind(kind),
    .target(target)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      target_q <= '0;
      bus.link_we <= 1'b0;
      bus.link_reg <= '0;
      bus.link_value <= '0;
    end else begin
      state <= state_n;
      bus.link_we <= accept & bus.dec_link;
      if (accept) target_q <= target;
      if (accept & bus.dec_link) begin
        bus.link_reg <= bus.dec_is_jr ? bus.dec_link_rd : LINK_REG;
        bus.link_value <= bus.dec_pc + LINK_OFFSET;
      end
    end
  // The delay-slot instruction is only counted here, never decoded as control.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = accept ? (taken ? SLOT : likely_miss ? NULLIFY : IDLE) : IDLE;
      SLOT:     state_n = issue ? REDIRECT : SLOT;
      REDIRECT: state_n = bus.stall ? REDIRECT : IDLE;
      NULLIFY:  state_n = issue ? IDLE : NULLIFY;
    endcase
  end
  always_comb begin
    bus.redirect_valid = state == REDIRECT;
    bus.redirect_pc = state == REDIRECT ? target_q : RESET_PC;
    bus.busy = state != IDLE;
`ifdef BRANCH_LIKELY_EN
    bus.nullify = (state == NULLIFY) & issue;
`else
    bus.nullify = 1'b0;
`endif
  end
endmodule

// File: tb/tb_branch_delay_ctrl.sv
// tb_branch_delay_ctrl: directed and random checks of branch_delay_ctrl against a behavioural model
module tb_branch_delay_ctrl;
  localparam logic [31:0] RST_PC = 32'hBFC00000;
`ifdef BRANCH_LIKELY_EN
  localparam logic [31:0] EXP_NULL = 32'd1;
`else
  localparam logic [31:0] EXP_NULL = 32'd0;
`endif
  logic clk, reset;
  int total = 0, bad = 0;
  bit redir, wait_slot, squash, exp_lw;
  logic [31:0] tgt, exp_lv;
  logic [4:0] exp_lr;
  branch_delay_ctrl_if bus();
  branch_delay_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic put(bit v, int k, bit lk, bit lik, bit ct, logic [31:0] pc, logic [15:0] imm,
                     logic [25:0] t26, logic [31:0] rs, logic [4:0] rd);
    bus.dec_valid = v;
    bus.dec_is_branch = k == 1;
    bus.dec_is_jump = k == 2;
    bus.dec_is_jr = k == 3;
    bus.dec_link = lk;
    bus.dec_likely = lik;
    bus.cmp_taken = ct;
    bus.dec_pc = pc;
    bus.dec_imm = imm;
    bus.dec_target26 = t26;
    bus.dec_rs_val = rs;
    bus.dec_link_rd = rd;
  endtask
  function automatic logic [31:0] ref_target();
    int off;
    off = $signed(bus.dec_imm);
    if (bus.dec_is_jr) return bus.dec_rs_val;
    if (bus.dec_is_jump) return ((bus.dec_pc + 32'd4) & 32'hF000_0000) | ({6'd0, bus.dec_target26} * 32'd4);
    return bus.dec_pc + 32'd4 + 32'(off * 4);
  endfunction
  // One clock: predict from current inputs, step the edge, compare registered outputs.
  task automatic cyc();
    bit issue;
    #2;
    chk("nullify", {31'd0, bus.nullify}, {31'd0, squash && bus.dec_valid && !bus.stall});
    issue = bus.dec_valid && !bus.stall;
    exp_lw = 0;
    if (redir) begin
      if (!bus.stall) redir = 0;
    end else if (wait_slot) begin
      if (issue) begin wait_slot = 0; redir = 1; end
    end else if (squash) begin
      if (issue) squash = 0;
    end else if (issue) begin
      exp_lw = bus.dec_link;
      exp_lr = bus.dec_is_jr ? bus.dec_link_rd : 5'd31;
      exp_lv = bus.dec_pc + 32'd8;
      if (bus.dec_is_jump || bus.dec_is_jr || (bus.dec_is_branch && bus.cmp_taken)) begin
        wait_slot = 1;
        tgt = ref_target();
      end else if (bus.dec_is_branch && bus.dec_likely && EXP_NULL[0]) squash = 1;
    end
    @(posedge clk);
    #1;
    chk("redirect_valid", {31'd0, bus.redirect_valid}, {31'd0, redir});
    chk("redirect_pc", bus.redirect_pc, redir ? tgt : RST_PC);
    chk("busy", {31'd0, bus.busy}, {31'd0, redir || wait_slot || squash});
    chk("link_we", {31'd0, bus.link_we}, {31'd0, exp_lw});
    if (exp_lw) begin
      chk("link_reg", {27'd0, bus.link_reg}, {27'd0, exp_lr});
      chk("link_value", bus.link_value, exp_lv);
    end
  endtask
  task automatic do_reset();
    reset = 1;
    #1;
    chk("rst_rv", {31'd0, bus.redirect_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_pc", bus.redirect_pc, RST_PC);
    chk("rst_lw", {31'd0, bus.link_we}, 32'd0);
    redir = 0; wait_slot = 0; squash = 0;
    @(posedge clk);
    #1;
    reset = 0;
  endtask
  initial begin
    bus.stall = 0;
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("init_rv", {31'd0, bus.redirect_valid}, 32'd0);
    chk("init_pc", bus.redirect_pc, RST_PC);
    chk("init_busy", {31'd0, bus.busy}, 32'd0);
    chk("init_lw", {31'd0, bus.link_we}, 32'd0);
    chk("init_null", {31'd0, bus.nullify}, 32'd0);
    chk("init_lv", bus.link_value, 32'd0);
    reset = 0;
    // BEQ taken
    put(1, 1, 0, 0, 1, 32'h00400010, 16'h0004, 0, 0, 0); cyc();
    chk("beq_busy", {31'd0, bus.busy}, 32'd1);
    put(1, 0, 0, 0, 0, 32'h00400014, 0, 0, 0, 0); cyc();
    chk("beq_rv", {31'd0, bus.redirect_valid}, 32'd1);
    chk("beq_pc", bus.redirect_pc, 32'h00400024);
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc();
    chk("beq_done", {31'd0, bus.redirect_valid}, 32'd0);
    // BNE not taken
    put(1, 1, 0, 0, 0, 32'h00400000, 16'h0010, 0, 0, 0); cyc();
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) begin
      cyc();
      chk("bne_rv", {31'd0, bus.redirect_valid}, 32'd0);
      chk("bne_busy", {31'd0, bus.busy}, 32'd0);
    end
    // JAL
    put(1, 2, 1, 0, 0, 32'h0040FFF8, 0, 26'h0000100, 0, 0); cyc();
    chk("jal_lw", {31'd0, bus.link_we}, 32'd1);
    chk("jal_lr", {27'd0, bus.link_reg}, 32'd31);
    chk("jal_lv", bus.link_value, 32'h00410000);
    put(1, 0, 0, 0, 0, 32'h0040FFFC, 0, 0, 0, 0); cyc();
    chk("jal_pc", bus.redirect_pc, 32'h00000400);
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc();
    // JALR with stalled slot
    put(1, 3, 1, 0, 0, 32'h00400200, 0, 0, 32'h80001234, 5'd5); cyc();
    chk("jalr_lr", {27'd0, bus.link_reg}, 32'd5);
    bus.stall = 1;
    put(1, 0, 0, 0, 0, 32'h00400204, 0, 0, 0, 0);
    repeat (3) begin
      cyc();
      chk("jalr_frz_busy", {31'd0, bus.busy}, 32'd1);
      chk("jalr_frz_rv", {31'd0, bus.redirect_valid}, 32'd0);
    end
    bus.stall = 0; cyc();
    chk("jalr_rv", {31'd0, bus.redirect_valid}, 32'd1);
    chk("jalr_pc", bus.redirect_pc, 32'h80001234);
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc();
    // Reset while in REDIRECT, then a backward branch
    put(1, 1, 0, 0, 1, 32'h00400300, 16'h0020, 0, 0, 0); cyc();
    put(1, 0, 0, 0, 0, 32'h00400304, 0, 0, 0, 0); cyc();
    chk("pre_rst_rv", {31'd0, bus.redirect_valid}, 32'd1);
    bus.stall = 1;
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    bus.stall = 0;
    put(1, 1, 0, 0, 1, 32'h00400040, 16'hFFFF, 0, 0, 0); cyc();
    put(1, 0, 0, 0, 0, 32'h00400044, 0, 0, 0, 0); cyc();
    chk("back_pc", bus.redirect_pc, 32'h00400040);
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc();
    // BEQL not taken
    put(1, 1, 0, 1, 0, 32'h00400100, 16'h0008, 0, 0, 0); cyc();
    put(1, 0, 0, 0, 0, 32'h00400104, 0, 0, 0, 0);
    #1;
    chk("beql_null", {31'd0, bus.nullify}, EXP_NULL);
    cyc();
    chk("beql_rv", {31'd0, bus.redirect_valid}, 32'd0);
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc();
    chk("beql_busy", {31'd0, bus.busy}, 32'd0);
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      int k;
      k = int'($urandom_range(0, 3));
      bus.stall = $urandom_range(0, 3) == 0;
      put($urandom_range(0, 9) < 7, k, k != 0 && $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1, $urandom, 16'($urandom), 26'($urandom), $urandom, 5'($urandom));
      if ($urandom_range(0, 99) == 0) do_reset();
      else cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
